frame_bram_arbiter: RTL and testbench
=====================================

Name: frame_bram_arbiter

Overview:
- Single-clock port controller for one port of the dual-port frame BRAM (15-bit address, 16-bit RGB565 word).
- Shares that port between two requesters (e.g. draw engine and sprite blitter) with round-robin arbitration.
- Contains a built-in clear sequencer that fills every address with a programmable colour, replacing the unimplemented clear function of the BRAM.
- Sits between the drawing logic and the BRAM; the other BRAM port stays dedicated to the OLED/VGA readout.

Parameters:
- N, 15, address width; the frame holds 2**N words.
- W, 16, data width (RGB565).

Ports:
- clk  in  1  system clock; also drives the BRAM port clock.
- reset  in  1  synchronous, active-high.
- req0  in  1  requester 0 transaction request, held until gnt0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  N  requester 0 address.
- wdata0  in  W  requester 0 write data.
- gnt0  out  1  combinational; high in the cycle req0 is accepted.
- rvalid0  out  1  requester 0 read data valid pulse.
- req1, we1, addr1, wdata1, gnt1, rvalid1  same as above, for requester 1.
- rdata  out  W  read data, shared by both requesters; qualify with rvalid0/rvalid1.
- clear_start  in  1  one-cycle pulse that starts a full-frame fill.
- clear_colour  in  W  fill value, sampled on clear_start.
- clear_busy  out  1  high while the fill runs.
- clear_done  out  1  one-cycle pulse after the last fill write.
- mem_addr  out  N  BRAM address, registered.
- mem_we  out  1  BRAM write enable, registered.
- mem_wdata  out  W  BRAM write data, registered.
- mem_rdata  in  W  BRAM read data; 1-cycle registered read latency.

Behaviour:
- States: IDLE, CLEAR. State transitions:
  - IDLE -> CLEAR on clear_start.
  - CLEAR -> IDLE after writing address 2**N-1.
- Reset values:
  - state = IDLE.
  - mem_addr, mem_we, mem_wdata = 0.
  - rvalid0, rvalid1, clear_busy, clear_done = 0.
  - rdata = 0; clear counter = 0.
  - last-grant pointer = 1, so requester 0 wins the first tie.
- Arbitration in IDLE, cycle t (no clear_start this cycle):
  - Only one req high: that requester gets its gnt.
  - Both req high: the requester not granted most recently gets its gnt.
  - At most one gnt per cycle; gnt is never high while its req is low.
  - The granted requester's addr/we/wdata are registered onto mem_* at the edge ending cycle t, so the BRAM sees them in cycle t+1.
  - The pointer updates to the granted index.
  - No grant in cycle t: mem_we = 0 in t+1; mem_addr holds its value.
- Read latency:
  - A read granted in cycle t gives rvalidX high for exactly one cycle in t+2.
  - In that cycle rdata = mem_rdata.
  - Back-to-back reads sustain one per cycle.
- Requester obligation: keep req/addr/we/wdata stable until gnt; the inputs may change in the cycle after gnt.
- Clear sequencer:
  - clear_start in IDLE has priority over req: no gnt that cycle.
  - It latches clear_colour and enters CLEAR; clear_busy = 1 from the next cycle.
  - In CLEAR, one write per cycle: mem_we = 1, mem_wdata = latched colour, mem_addr = 0, 1, ... 2**N-1 (2**N consecutive write cycles).
  - gnt0 and gnt1 stay 0 throughout CLEAR; pending reqs wait.
  - After the cycle that writes address 2**N-1:
    - clear_busy drops.
    - clear_done pulses for 1 cycle.
    - mem_we = 0.
    - Arbitration resumes that same cycle.
- clear_start while in CLEAR is ignored: the colour does not change and the counter does not restart.
- Reads granted in the two cycles before clear_start still complete with their rvalid.
- Reset mid-fill aborts immediately: clear_busy = 0, no clear_done, and the addresses not yet written keep their old contents.
- Address counter is N bits wide and wraps from 2**N-1 to 0 only on the terminal transition; it never exceeds the frame.

Test Plan:
- N=4. Reset, then req0 write addr 3 data 16'hF800 -> gnt0 in the same cycle; next cycle mem_we=1, mem_addr=3, mem_wdata=F800. Read back addr 3 -> rvalid0 two cycles after gnt0, rdata=F800.
- req0 and req1 held high, all writes, 4 cycles -> grants alternate 0,1,0,1 starting with 0; mem_addr alternates addr0/addr1.
- clear_start with clear_colour=16'h07E0 while req1 pending -> no gnt1 for 16 cycles; 16 writes to addr 0..15 with data 07E0; clear_done pulses once; gnt1 in the cycle clear_busy drops.
- Second clear_start (colour 001F) pulsed mid-fill -> ignored; all 16 locations read back 07E0.
- Reset asserted at fill address 7 -> clear_busy=0, no clear_done; addresses 8..15 read back their prior values.
- Read granted one cycle before clear_start -> rvalid still pulses with correct data; the fill starts on schedule.

Source files
------------

// File: rtl/frame_bram_arbiter.sv
// frame_bram_arbiter
//   Port controller for one port of the dual-port frame BRAM. Two requesters
//   share the port with round-robin arbitration. A built-in clear sequencer
//   fills every address with a programmable colour.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req/we/addr/wdata{0,1}      requester transaction inputs (held until gnt)
//   gnt{0,1}                    combinational grant, high in the accept cycle
//   rvalid{0,1}, rdata          read return, two cycles after the grant
//   clear_start, clear_colour   start a full-frame fill with this colour
//   clear_busy, clear_done      fill in progress / one-cycle completion pulse
//   mem_addr/we/wdata           registered BRAM port controls
//   mem_rdata                   BRAM read data (1-cycle registered latency)
module frame_bram_arbiter #(
    parameter int N = 15,
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic         we0,
    input  logic [N-1:0] addr0,
    input  logic [W-1:0] wdata0,
    output logic         gnt0,
    output logic         rvalid0,
    input  logic         req1,
    input  logic         we1,
    input  logic [N-1:0] addr1,
    input  logic [W-1:0] wdata1,
    output logic         gnt1,
    output logic         rvalid1,
    output logic [W-1:0] rdata,
    input  logic         clear_start,
    input  logic [W-1:0] clear_colour,
    output logic         clear_busy,
    output logic         clear_done,
    output logic [N-1:0] mem_addr,
    output logic         mem_we,
    output logic [W-1:0] mem_wdata,
    input  logic [W-1:0] mem_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   mem_addr_q, mem_addr_d;
    logic           mem_we_q, mem_we_d;
    logic [W-1:0]   mem_wdata_q, mem_wdata_d;
    logic           last_q, last_d;       // index granted most recently
    logic [N-1:0]   cnt_q, cnt_d;         // next fill address to issue
    logic [W-1:0]   colour_q, colour_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           rd0_p_q, rd0_p_d;     // read issued to BRAM this cycle
    logic           rd1_p_q, rd1_p_d;
    logic           rvalid0_q, rvalid0_d;
    logic           rvalid1_q, rvalid1_d;

    // Grants only in IDLE and never in a clear_start cycle.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE && !clear_start) begin
            gnt0 = req0 && (!req1 || last_q);
            gnt1 = req1 && !gnt0;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        colour_d    = colour_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rd0_p_d     = gnt0 && !we0;
        rd1_p_d     = gnt1 && !we1;
        rvalid0_d   = rd0_p_q;
        rvalid1_d   = rd1_p_q;

        case (state_q)
            IDLE: begin
                if (clear_start) begin
                    state_d  = CLEAR;
                    colour_d = clear_colour;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                end else if (gnt0) begin
                    mem_addr_d  = addr0;
                    mem_we_d    = we0;
                    mem_wdata_d = wdata0;
                    last_d      = 1'b0;
                end else if (gnt1) begin
                    mem_addr_d  = addr1;
                    mem_we_d    = we1;
                    mem_wdata_d = wdata1;
                    last_d      = 1'b1;
                end
            end
            CLEAR: begin
                // The first CLEAR cycle always has mem_we_q low (no grant in
                // the clear_start cycle), so seeing the top address being
                // written means the fill has just finished.
                if (mem_we_q && mem_addr_q == '1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cnt_q;
                    mem_wdata_d = colour_q;
                    cnt_d       = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            colour_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd0_p_q     <= 1'b0;
            rd1_p_q     <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            colour_q    <= colour_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd0_p_q     <= rd0_p_d;
            rd1_p_q     <= rd1_p_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_we     = mem_we_q;
    assign mem_wdata  = mem_wdata_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign rvalid0    = rvalid0_q;
    assign rvalid1    = rvalid1_q;
    // BRAM output is already registered; pass it through only when qualified.
    assign rdata      = (rvalid0_q || rvalid1_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_frame_bram_arbiter.sv
module tb_frame_bram_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0, we0, req1, we1;
    logic [N-1:0] addr0, addr1;
    logic [W-1:0] wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0] rdata;
    logic         clear_start;
    logic [W-1:0] clear_colour;
    logic         clear_busy, clear_done;
    logic [N-1:0] mem_addr;
    logic         mem_we;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    frame_bram_arbiter #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .clear_busy(clear_busy), .clear_done(clear_done),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model: write-through storage, registered read-first output.
    logic [W-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Single read through requester 0; ends in the rvalid cycle.
    task automatic read0(input logic [N-1:0] a, input logic [W-1:0] exp, input string tag);
        req0 = 1'b1; we0 = 1'b0; addr0 = a;
        #1 chk({tag, "_gnt"}, gnt0, 1);
        tick;
        req0 = 1'b0;
        chk({tag, "_rv_early"}, rvalid0, 0);
        tick;
        chk({tag, "_rv"}, rvalid0, 1);
        chk({tag, "_rdata"}, rdata, exp);
    endtask

    initial begin
        int done_cnt;
        bit seen;
        reset = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        clear_start = 0; clear_colour = 0;
        repeat (3) tick;

        // Reset state
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_busy", clear_busy, 0);
        chk("rst_done", clear_done, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1'b0;
        tick;

        // Single write then read-back
        req0 = 1; we0 = 1; addr0 = 3; wdata0 = 16'hF800;
        #1 chk("wr_gnt0", gnt0, 1);
        chk("wr_gnt1", gnt1, 0);
        tick;
        req0 = 0;
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 3);
        chk("wr_mem_wdata", mem_wdata, 16'hF800);
        read0(3, 16'hF800, "rd3");
        tick;
        chk("rd3_rv_pulse", rvalid0, 0);
        chk("idle_mem_we", mem_we, 0);

        // Make requester 1 the most recent winner, then alternate
        req1 = 1; we1 = 1; addr1 = 12; wdata1 = 16'h1234;
        #1 chk("solo_gnt1", gnt1, 1);
        tick;
        req0 = 1; we0 = 1; addr0 = 5; wdata0 = 16'h1111;
        req1 = 1; we1 = 1; addr1 = 9; wdata1 = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2 == 0));
            chk($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2 == 1));
            tick;
            chk($sformatf("rr_addr_%0d", i), mem_addr, (i % 2 == 0) ? 5 : 9);
        end
        req0 = 0; req1 = 0;
        tick;

        // Clear with req1 read pending; second clear_start mid-fill
        clear_start = 1; clear_colour = 16'h07E0;
        req1 = 1; we1 = 0; addr1 = 4;
        #1 chk("clr_start_gnt1", gnt1, 0);
        chk("clr_start_gnt0", gnt0, 0);
        tick;
        clear_start = 0;
        done_cnt = 0;
        chk("clr_busy_first", clear_busy, 1);
        chk("clr_gnt1_first", gnt1, 0);
        for (int k = 0; k < 16; k++) begin
            tick;
            clear_start = 0;
            if (clear_done) done_cnt++;
            chk($sformatf("clr_we_%0d", k), mem_we, 1);
            chk($sformatf("clr_addr_%0d", k), mem_addr, k);
            chk($sformatf("clr_data_%0d", k), mem_wdata, 16'h07E0);
            chk($sformatf("clr_gnt1_%0d", k), gnt1, 0);
            chk($sformatf("clr_busy_%0d", k), clear_busy, 1);
            if (k == 5) begin
                clear_start = 1; clear_colour = 16'h001F;
            end
        end
        chk("clr_no_early_done", done_cnt, 0);
        tick;
        chk("clr_end_busy", clear_busy, 0);
        chk("clr_end_done", clear_done, 1);
        chk("clr_end_we", mem_we, 0);
        #1 chk("clr_end_gnt1", gnt1, 1);
        tick;
        req1 = 0;
        chk("clr_done_pulse", clear_done, 0);
        chk("post_rd_addr", mem_addr, 4);
        chk("post_rd_we", mem_we, 0);
        tick;
        chk("post_rd_rv1", rvalid1, 1);
        chk("post_rd_rdata", rdata, 16'h07E0);

        // Back-to-back readback of whole frame
        for (int i = 0; i < 18; i++) begin
            if (i < 16) begin
                req0 = 1; we0 = 0; addr0 = i[N-1:0];
            end else begin
                req0 = 0;
            end
            #1;
            if (i < 16) chk($sformatf("rb_gnt_%0d", i), gnt0, 1);
            if (i >= 2) begin
                chk($sformatf("rb_rv_%0d", i - 2), rvalid0, 1);
                chk($sformatf("rb_data_%0d", i - 2), rdata, 16'h07E0);
            end
            tick;
        end
        req0 = 0;

        // Prior values at 8..15, then reset mid-fill at address 7
        for (int a = 8; a < 16; a++) begin
            req1 = 1; we1 = 1; addr1 = a[N-1:0]; wdata1 = 16'hC000 + 16'(a);
            #1 chk($sformatf("pre_gnt1_%0d", a), gnt1, 1);
            tick;
        end
        req1 = 0;
        tick;
        clear_start = 1; clear_colour = 16'h001F;
        tick;
        clear_start = 0;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk($sformatf("abort_addr_%0d", k), mem_addr, k);
        end
        reset = 1;
        tick;
        reset = 0;
        chk("abort_busy", clear_busy, 0);
        chk("abort_done", clear_done, 0);
        chk("abort_we", mem_we, 0);
        seen = 0;
        repeat (20) begin
            tick;
            if (clear_done || mem_we) seen = 1;
        end
        chk("abort_quiet", seen, 0);
        read0(7, 16'h001F, "abort_rd7");
        read0(0, 16'h001F, "abort_rd0");
        for (int a = 8; a < 16; a++)
            read0(a[N-1:0], 16'hC000 + 16'(a), $sformatf("abort_rd%0d", a));

        // Read granted one cycle before clear_start
        tick;
        req0 = 1; we0 = 0; addr0 = 9;
        #1 chk("pre_clr_gnt0", gnt0, 1);
        tick;
        req0 = 0;
        clear_start = 1; clear_colour = 16'h1234;
        tick;
        clear_start = 0;
        chk("pre_clr_rv0", rvalid0, 1);
        chk("pre_clr_rdata", rdata, 16'hC009);
        chk("pre_clr_busy", clear_busy, 1);
        tick;
        chk("pre_clr_we0", mem_we, 1);
        chk("pre_clr_addr0", mem_addr, 0);
        chk("pre_clr_data0", mem_wdata, 16'h1234);
        seen = 0;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick;
            if (clear_done) seen = 1;
        end
        chk("pre_clr_done_seen", seen, 1);
        chk("pre_clr_busy_end", clear_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
